// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: inter-stage pipeline buffer; DEPTH=1 plain register, DEPTH>=2 elastic FIFO; PIPE_STAT_EN adds stall/bubble counters
module pipe_stage_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             up_ready_go,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             allow_in,
    output logic             dn_valid,
    output logic [WIDTH-1:0] dn_data,
    input  logic             dn_accept,
    output logic [2:0]       count
`ifdef PIPE_STAT_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      bubble_cnt
`endif
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             push, pop;

    // explicit wrap so non-power-of-two depths cycle 0..DEPTH-1
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign dn_valid = count != 3'd0;
    assign dn_data  = dn_valid ? mem[rd_ptr] : '0;
    assign allow_in = (DEPTH == 1) ? (~dn_valid | dn_accept) : (count < 3'(DEPTH));
    assign push     = up_ready_go & up_valid & allow_in;
    assign pop      = dn_valid & dn_accept;

    // storage, pointers and occupancy; reset and flush both empty and zero the buffer
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= up_data;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop) rd_ptr <= nxt(rd_ptr);
            if (push && !pop) count <= count + 3'd1;
            else if (pop && !push) count <= count - 3'd1;
        end
    end

`ifdef PIPE_STAT_EN
    // stall/bubble statistics; cleared only by reset, wrap naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (dn_valid && !dn_accept) stall_cnt <= stall_cnt + 32'd1;
            if (!dn_valid && dn_accept) bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    // handshake sanity: no pop from empty, no push into a full FIFO
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(pop && count == 3'd0)) else $error("pop while empty");
            if (DEPTH > 1) assert (!(push && count == 3'(DEPTH))) else $error("push while full");
        end
    end
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: scoreboard bench for pipe_stage_buf at DEPTH 1, 2 and 3 (stat counters when PIPE_STAT_EN)
module tb_pipe_stage_buf;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  rg = '0, uv = '0, acc = '0, fl = '0;
    logic [2:0]  allow, dv;
    logic [31:0] ud [3];
    logic [31:0] dd [3];
    logic [2:0]  cnt [3];
    logic [31:0] mq [$];
    int          n_chk = 0, n_fail = 0;
    bit          took;
    int          idx;
`ifdef PIPE_STAT_EN
    logic [31:0] stall_cnt, bubble_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stage_buf #(.WIDTH(32), .DEPTH(1)) u1 (
        .clk(clk), .reset(reset), .flush(fl[0]), .up_ready_go(rg[0]), .up_valid(uv[0]),
        .up_data(ud[0]), .allow_in(allow[0]), .dn_valid(dv[0]), .dn_data(dd[0]),
        .dn_accept(acc[0]), .count(cnt[0])
`ifdef PIPE_STAT_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );
    pipe_stage_buf #(.WIDTH(32), .DEPTH(2)) u2 (
        .clk(clk), .reset(reset), .flush(fl[1]), .up_ready_go(rg[1]), .up_valid(uv[1]),
        .up_data(ud[1]), .allow_in(allow[1]), .dn_valid(dv[1]), .dn_data(dd[1]),
        .dn_accept(acc[1]), .count(cnt[1])
    );
    pipe_stage_buf #(.WIDTH(32), .DEPTH(3)) u3 (
        .clk(clk), .reset(reset), .flush(fl[2]), .up_ready_go(rg[2]), .up_valid(uv[2]),
        .up_data(ud[2]), .allow_in(allow[2]), .dn_valid(dv[2]), .dn_data(dd[2]),
        .dn_accept(acc[2]), .count(cnt[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rg = '0; uv = '0; acc = '0; fl = '0;
        for (int k = 0; k < 3; k++) ud[k] = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mq.delete();
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_count", 32'(cnt[k]), 0);
            check("rst_valid", 32'(dv[k]), 0);
            check("rst_allow", 32'(allow[k]), 1);
            check("rst_data", dd[k], 0);
        end
    endtask

    // one clock on instance k (DEPTH = k+1); model decides allow/push/pop, DUT output checked against queue head
    task automatic step(input int k, input bit g, input bit v, input logic [31:0] d, input bit a, input bit f);
        bit mal, pu, po;
        rg[k] = g; uv[k] = v; ud[k] = d; acc[k] = a; fl[k] = f;
        #1;
        mal = (k == 0) ? (mq.size() == 0 || a) : (mq.size() < k + 1);
        check("allow_in", 32'(allow[k]), 32'(mal));
        check("dn_valid", 32'(dv[k]), 32'(mq.size() != 0));
        if (mq.size() == 0) check("dn_data_idle", dd[k], 0);
        po = mq.size() != 0 && a && !f;
        pu = g && v && mal && !f;
        if (po) check("pop_data", dd[k], mq.pop_front());
        if (f) mq.delete();
        if (pu) mq.push_back(d);
        took = pu;
        @(negedge clk);
        check("count", 32'(cnt[k]), 32'(mq.size()));
    endtask

    initial begin
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 1, 1, (i < 3) ? 32'hA5A5A5A5 : 32'h5A5A5A5A, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 1, 1, 32'hC3, 0, 0);
        step(0, 1, 1, 32'hD4, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(1, 1, 1, 32'h11, 0, 0);
        step(1, 1, 1, 32'h22, 0, 0);
        step(1, 1, 1, 32'h33, 0, 0);
        step(1, 1, 1, 32'h34, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        step(1, 1, 1, 32'h66, 0, 0);
        step(1, 1, 1, 32'h77, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            step(2, idx < 10, 1, 32'(idx), (c % 2) == 0, 0);
            if (took) idx++;
        end
        check("all_pushed", 32'(idx), 10);
        repeat (4) step(2, 0, 0, 0, 1, 0);
        step(1, 1, 1, 32'hA1, 0, 0);
        step(1, 1, 1, 32'hA2, 0, 0);
        step(1, 1, 1, 32'h44, 1, 1);
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        repeat (3) step(1, 1, 0, 32'h99, 1, 0);
        step(1, 1, 1, 32'h55, 0, 0);
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 1, 32'hBB, 1, 0);
        step(1, 0, 0, 0, 0, 0);
`ifdef PIPE_STAT_EN
        do_reset();
        step(0, 1, 1, 32'h77, 0, 0);
        repeat (5) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        repeat (2) step(0, 0, 0, 0, 1, 0);
        check("stall_cnt", stall_cnt, 5);
        check("bubble_cnt", bubble_cnt, 2);
        do_reset();
        check("stall_rst", stall_cnt, 0);
        check("bubble_rst", bubble_cnt, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
